// File: rtl/xxdcf_frame_loader.sv
// Assembles eight 3-bit lane beats into the two-word xxdcf frame behind a double buffer.
// Latency: frame valid the cycle after its 8th beat is accepted; one beat per cycle.
// Backpressure: in_ready drops while a completed frame waits for the busy output register, or during flush/reset.
module xxdcf_frame_loader #(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:4]              in_lane,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:1][3:0][2:4]    out_frame [2:3],
    output logic [CNT_W-1:0]        frame_count
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t                 state;
    logic [2:0]             cnt;
    logic [3:2][3:0][2:4]   asm_q;
    logic [3:2][3:0][2:4]   asm_nxt;
    logic [1:0]             lane_idx;
    logic [1:0]             word_idx;
    logic                   accept;
    logic                   take;
    logic                   last_beat;
    logic                   out_free;
    logic                   load;

    assign in_ready  = ~rst & ~flush & (state == FILL);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign last_beat = (cnt == 3'd7);
    assign out_free  = ~out_valid | out_ready;
    assign lane_idx  = 2'd3 - cnt[1:0];
    assign word_idx  = {1'b1, cnt[2]};

    // A held frame moves out only if the same cycle does not flush it away.
    assign load = (accept & last_beat & out_free)
                | ((state == HOLD) & take & ~flush);

    always_comb begin
        asm_nxt = asm_q;
        if (accept) begin
            asm_nxt[word_idx][lane_idx] = in_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            cnt          <= 3'd0;
            asm_q        <= '0;
            out_valid    <= 1'b0;
            out_frame[2] <= '0;
            out_frame[3] <= '0;
            frame_count  <= '0;
        end else begin
            asm_q <= asm_nxt;

            if (take) begin
                frame_count <= frame_count + CNT_ONE;
            end

            if (load) begin
                out_frame[2] <= asm_nxt[2];
                out_frame[3] <= asm_nxt[3];
                out_valid    <= 1'b1;
            end else if (take) begin
                out_valid <= 1'b0;
            end

            if (flush) begin
                cnt   <= 3'd0;
                state <= FILL;
            end else if (state == FILL) begin
                if (accept) begin
                    if (last_beat) begin
                        cnt <= 3'd0;
                        if (!out_free) begin
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
            end else if (take) begin
                state <= FILL;
            end
        end
    end

endmodule

// File: tb/tb_xxdcf_frame_loader.sv
// Directed bench for xxdcf_frame_loader with a frame scoreboard and a 2-bit delivered-frame counter.
module tb_xxdcf_frame_loader;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [2:4]             in_lane;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:1][3:0][2:4]   out_frame [2:3];
    logic [1:0]             frame_count;

    xxdcf_frame_loader #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lane     (in_lane),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_frame   (out_frame),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [23:0] q [$];
    logic [23:0] mbuf = '0;
    int          mcnt = 0;
    int          fc = 0;
    logic        last_acc = 1'b0;

    function automatic logic [23:0] cur_frame();
        return {out_frame[3], out_frame[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, update the model, check outputs after the rising edge.
    task automatic tick();
        logic took, acc, fl, r;
        @(negedge clk);
        r    = rst;
        fl   = flush;
        took = out_valid && out_ready;
        acc  = in_valid && in_ready;
        chk("in_ready", in_ready, (!r && !fl && q.size() < 2));
        last_acc = acc;
        if (!r && took && q.size() != 0) chk("take_frame", cur_frame(), q[0]);
        if (r) begin
            q.delete();
            mcnt = 0;
            fc   = 0;
        end else begin
            if (fl) begin
                mcnt = 0;
                if (q.size() == 2) void'(q.pop_back());
            end
            if (took && q.size() != 0) begin
                void'(q.pop_front());
                fc = (fc + 1) % 4;
            end
            if (acc) begin
                mbuf[(mcnt / 4) * 12 + (3 - (mcnt % 4)) * 3 +: 3] = in_lane;
                mcnt++;
                if (mcnt == 8) begin
                    q.push_back(mbuf);
                    mcnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, (q.size() != 0));
        chk("frame_count", frame_count, fc);
        if (q.size() != 0) chk("out_frame", cur_frame(), q[0]);
    endtask

    task automatic send(input logic [2:0] v);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_lane  = v;
        last_acc = 1'b0;
        while (!last_acc && n < 40) begin
            tick();
            n++;
        end
        if (!last_acc) begin
            n_asrt++;
            n_fail++;
            $error("FAIL send_timeout: beat %0d not accepted within %0d cycles", v, n);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fc_b;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_lane   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_frame", cur_frame(), 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // Beats 0..7 with the consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(3'(k));
        chk("t1_valid", out_valid, 1);
        chk("t1_frame", cur_frame(), 24'o45670123);
        tick();
        chk("t1_count", frame_count, 1);
        out_ready = 1'b0;

        // Two frames against a stalled consumer: second frame waits in HOLD.
        for (int k = 0; k < 16; k++) send(3'((k * 3) % 8));
        chk("hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_exit_ready", in_ready, 1);
        chk("hold_exit_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_count", frame_count, 3);

        // Partial frame discarded by flush; beat offered during flush is refused.
        for (int k = 0; k < 5; k++) send(3'(k));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_lane  = 3'd5;
        tick();
        chk("flush_no_accept", last_acc, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) send(3'd7);
        chk("flush_frame", cur_frame(), 24'o77777777);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Take coincides with the 8th beat of the next frame.
        for (int k = 0; k < 8; k++) send(3'(k));
        for (int k = 0; k < 7; k++) send(3'(7 - k));
        fc_b      = fc;
        out_ready = 1'b1;
        send(3'd0);
        out_ready = 1'b0;
        chk("switch_valid", out_valid, 1);
        chk("switch_frame", cur_frame(), 24'o32107654);
        chk("switch_count", frame_count, (fc_b + 1) % 4);
        out_ready = 1'b1;
        tick();

        // Five more frames with the consumer ready; 2-bit counter wraps.
        for (int k = 0; k < 40; k++) send(3'((k + k / 8) % 8));
        tick();
        tick();
        out_ready = 1'b0;
        chk("wrap_count", frame_count, 3);

        // Reset while a frame is held and the output is valid.
        for (int k = 0; k < 16; k++) send(3'(k % 8));
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_count", frame_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
